// File: rtl/cpu_pkg.sv
// Shared opcode, ALU select and FSM state definitions for the control path.
package cpu_pkg;

  localparam logic [3:0] OP_ADDI  = 4'b1000;
  localparam logic [3:0] OP_BEQZ  = 4'b1010;
  localparam logic [3:0] OP_BGTZ  = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // R-type opcodes 0000-0111 map straight onto codes 0-7
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;
  localparam logic [3:0] ALU_PASS_A = 4'd8;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm_data;
    logic [7:0]  target;
    logic [3:0]  alu_sel;
    logic        imm_sel;
    logic        wr_rf;
    logic        wr_mem;
    logic        beqz;
    logic        bgtz;
    logic        jmp;
    logic        halt;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of a 16-bit instruction word into control fields.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] instr_i,
  output decode_t     dec_o
);

  logic [3:0] op;
  assign op = instr_i[15:12];

  always_comb begin
    dec_o          = '0;
    dec_o.rd       = instr_i[11:9];
    dec_o.rs       = instr_i[8:6];
    dec_o.rt       = instr_i[5:3];
    dec_o.imm_data = {{10{instr_i[5]}}, instr_i[5:0]};
    dec_o.target   = instr_i[7:0];
    dec_o.alu_sel  = ALU_ADD;
    if (!op[3]) begin
      dec_o.alu_sel = {1'b0, op[2:0]};
      dec_o.wr_rf   = 1'b1;
    end else begin
      case (op)
        OP_ADDI: begin
          dec_o.imm_sel = 1'b1;
          dec_o.wr_rf   = 1'b1;
        end
        OP_BEQZ: begin
          dec_o.alu_sel = ALU_PASS_A;
          dec_o.beqz    = 1'b1;
        end
        OP_BGTZ: begin
          dec_o.alu_sel = ALU_PASS_A;
          dec_o.bgtz    = 1'b1;
        end
        OP_JMP:   dec_o.jmp = 1'b1;
        OP_STORE: begin
          dec_o.imm_sel = 1'b1;
          dec_o.wr_mem  = 1'b1;
        end
        OP_HALT:  dec_o.halt = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FSM controller: owns pc, instruction register and write strobes.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [15:0]     instr,
  input  logic            zero_flag,
  input  logic            pos_flag,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      rs_addr,
  output logic [2:0]      rt_addr,
  output logic [2:0]      rd_addr,
  output logic [15:0]     imm_data,
  output logic [3:0]      alu_sel,
  output logic            imm_sel,
  output logic            rf_write,
  output logic            mem_write,
  output logic            halted
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic            rf_write_q;
  logic            mem_write_q;
  logic            halted_q;

  decode_t         dec;
  logic            taken;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_tgt;

  instr_decoder u_instr_decoder (
    .instr_i (ir_q),
    .dec_o   (dec)
  );

  assign taken   = (dec.beqz & zero_flag) | (dec.bgtz & pos_flag & ~zero_flag);
  assign br_off  = PC_W'($signed(dec.imm_data));
  assign jmp_tgt = PC_W'(dec.target);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      ir_q        <= '0;
      rf_write_q  <= 1'b0;
      mem_write_q <= 1'b0;
      halted_q    <= 1'b0;
    end else if (enable) begin
      unique case (state_q)
        StFetch: begin
          ir_q    <= instr;
          pc_q    <= pc_q + PC_W'(1);
          state_q <= StDecode;
        end
        StDecode: state_q <= StExecute;
        StExecute: begin
          // pc already points past this instruction, so offsets are relative to pc+1
          if (dec.jmp) begin
            pc_q <= jmp_tgt;
          end else if (taken) begin
            pc_q <= pc_q + br_off;
          end
          if (dec.halt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (dec.wr_rf || dec.wr_mem) begin
            state_q     <= StWriteback;
            rf_write_q  <= dec.wr_rf;
            mem_write_q <= dec.wr_mem;
          end else begin
            state_q <= StFetch;
          end
        end
        StWriteback: begin
          rf_write_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= StFetch;
        end
        StHalt: ;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign pc        = pc_q;
  assign rd_addr   = dec.rd;
  assign rs_addr   = dec.rs;
  assign rt_addr   = dec.rt;
  assign imm_data  = dec.imm_data;
  assign alu_sel   = dec.alu_sel;
  assign imm_sel   = dec.imm_sel;
  assign rf_write  = rf_write_q;
  assign mem_write = mem_write_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: directed scenarios plus random instructions against a
// transaction-level model (per-instruction latency, strobe slot and next pc).
module tb_control_unit;
  import cpu_pkg::*;

  localparam int unsigned PC_W = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [15:0]     instr;
  logic            zero_flag;
  logic            pos_flag;
  logic [PC_W-1:0] pc;
  logic [2:0]      rs_addr, rt_addr, rd_addr;
  logic [15:0]     imm_data;
  logic [3:0]      alu_sel;
  logic            imm_sel, rf_write, mem_write, halted;

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] pc_m;

  control_unit #(.PC_W(PC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .instr     (instr),
    .zero_flag (zero_flag),
    .pos_flag  (pos_flag),
    .pc        (pc),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .imm_data  (imm_data),
    .alu_sel   (alu_sel),
    .imm_sel   (imm_sel),
    .rf_write  (rf_write),
    .mem_write (mem_write),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] ref_alu(input logic [3:0] op);
    if (op < 4'd8) return op;
    if (op == 4'hA || op == 4'hB) return ALU_PASS_A;
    return ALU_ADD;
  endfunction

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; instr = '0; zero_flag = 1'b0; pos_flag = 1'b0;
    tick;
    tick;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_imm", 32'({imm_data, imm_sel, rd_addr, rs_addr, rt_addr}), 32'd0);
    reset = 1'b0;
    pc_m  = '0;
  endtask

  // Runs one instruction from FETCH to the next FETCH (or into HALT).
  task automatic do_instr(input logic [15:0] ins, input logic z, input logic p, input bit stall);
    logic [3:0]      op;
    logic [PC_W-1:0] pc_inc, pc_fin, exp_pc, off;
    logic [15:0]     sext;
    bit              wrf, st, hlt, take, en;
    int              lat, k, guard;
    op     = ins[15:12];
    wrf    = (op < 4'd9);
    st     = (op == 4'hD);
    hlt    = (op == 4'hF);
    take   = (op == 4'hA && z) || (op == 4'hB && p && !z);
    sext   = {{10{ins[5]}}, ins[5:0]};
    off    = sext[PC_W-1:0];
    pc_inc = pc_m + 8'd1;
    if (op == 4'hC)  pc_fin = ins[7:0];
    else if (take)   pc_fin = pc_inc + off;
    else             pc_fin = pc_inc;
    lat    = (wrf || st) ? 4 : 3;
    k      = 0;
    guard  = 0;
    instr  = ins; zero_flag = z; pos_flag = p;
    while (k < lat && guard < 200) begin
      en     = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      enable = en;
      tick;
      guard++;
      if (en) k++;
      if (k >= 1) instr = 16'($urandom);
      exp_pc = (k == 0) ? pc_m : ((k >= 3) ? pc_fin : pc_inc);
      check("pc", 32'(pc), 32'(exp_pc));
      check("rf_write", 32'(rf_write), 32'(k == 3 && wrf));
      check("mem_write", 32'(mem_write), 32'(k == 3 && st));
      check("halted", 32'(halted), 32'(hlt && k >= 3));
      if (k >= 1 && (k <= 2 || (k == 3 && (wrf || st)))) begin
        check("rd_addr", 32'(rd_addr), 32'(ins[11:9]));
        check("rs_addr", 32'(rs_addr), 32'(ins[8:6]));
        check("rt_addr", 32'(rt_addr), 32'(ins[5:3]));
        check("imm_data", 32'(imm_data), 32'(sext));
        check("alu_sel", 32'(alu_sel), 32'(ref_alu(op)));
        check("imm_sel", 32'(imm_sel), 32'(op == 4'h8 || op == 4'hD));
      end
    end
    if (k != lat) check("timeout", 32'(k), 32'(lat));
    pc_m = pc_fin;
  endtask

  initial begin
    logic [3:0] op;
    logic       z, p;

    do_reset();
    do_instr(16'h8205, 1'b0, 1'b0, 1'b0);
    check("addi_pc", 32'(pc), 32'd1);

    do_instr(16'hC00A, 1'b0, 1'b0, 1'b0);
    do_instr(16'hA0BE, 1'b1, 1'b0, 1'b0);
    check("beqz_taken_pc", 32'(pc), 32'd9);
    do_instr(16'hC00A, 1'b0, 1'b0, 1'b0);
    do_instr(16'hA0BE, 1'b0, 1'b0, 1'b0);
    check("beqz_not_taken_pc", 32'(pc), 32'd11);

    do_instr(16'hB043, 1'b1, 1'b1, 1'b0);
    check("bgtz_zero_pc", 32'(pc), 32'd12);
    do_instr(16'hB043, 1'b0, 1'b1, 1'b0);
    check("bgtz_pos_pc", 32'(pc), 32'd16);

    do_instr(16'hC0FF, 1'b0, 1'b0, 1'b0);
    do_instr(16'h9000, 1'b0, 1'b0, 1'b0);
    check("wrap_pc", 32'(pc), 32'd0);
    do_instr(16'hC080, 1'b0, 1'b0, 1'b0);
    check("jmp_pc", 32'(pc), 32'h80);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 14));
      z  = 1'($urandom_range(0, 1));
      p  = 1'($urandom_range(0, 1));
      do_instr({op, 12'($urandom)}, z, p, 1'b1);
    end

    // async reset in the middle of a writeback
    do_reset();
    instr  = 16'h8205;
    enable = 1'b1;
    tick; tick; tick;
    check("wb_strobe", 32'(rf_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rf_write", 32'(rf_write), 32'd0);
    check("async_pc", 32'(pc), 32'd0);
    tick;
    reset = 1'b0;
    pc_m  = '0;

    do_instr(16'h8205, 1'b0, 1'b0, 1'b1);
    do_instr(16'hF000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      enable = 1'($urandom_range(0, 1));
      instr  = 16'($urandom);
      tick;
      check("halt_pc", 32'(pc), 32'(pc_m));
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_strobes", 32'({rf_write, mem_write}), 32'd0);
    end
    #2 reset = 1'b1;
    #1;
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_rst_pc", 32'(pc), 32'd0);
    tick;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
